// File: rtl/serial_pkg.sv
// Shared types and constants for the shared serial shift-link arbiter.
package serial_pkg;

  localparam int unsigned SER_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH,
    DONE
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant selection: the first requester after the pointer wins,
// and the pointer moves to the winner when the grant is accepted.
module rr_arbiter #(
  parameter int unsigned NREQ = 2,
  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            accept,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   gnt_idx
);

  logic [PW-1:0] ptr;
  logic          found;

  // Two passes: indices above the pointer first, then the wrap-around.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    gnt     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && req[i] && (PW'(i) > ptr)) begin
        found   = 1'b1;
        gnt_idx = PW'(i);
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && req[i] && (PW'(i) <= ptr)) begin
        found   = 1'b1;
        gnt_idx = PW'(i);
      end
    end
    if (found) gnt[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= PW'(NREQ - 1);
    end else if (accept && found) begin
      ptr <= gnt_idx;
    end
  end

endmodule

// File: rtl/serial_link_arb.sv
// Shares one 8-bit full-duplex serial shift link between NREQ requesters,
// with round-robin arbitration and an idle-timeout refresh transfer.
module serial_link_arb
  import serial_pkg::*;
#(
  parameter int unsigned NREQ           = 2,
  parameter int unsigned HALF_DIV       = 1024,
  parameter int unsigned REFRESH_PERIOD = 8388608
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req,
  input  logic [SER_BYTE_W*NREQ-1:0] req_data,
  output logic [NREQ-1:0]            gnt,
  output logic [NREQ-1:0]            done,
  output logic [SER_BYTE_W-1:0]      rx_data,
  output logic                       busy,
  output logic                       sclk,
  output logic                       sdata,
  input  logic                       sdatain,
  output logic                       slatch
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned HW = $clog2(HALF_DIV + 1);
  localparam int unsigned RW = $clog2(REFRESH_PERIOD);

  state_t                state, state_nxt;
  logic [HW-1:0]         hcnt;
  logic                  phase;
  logic [2:0]            bit_cnt;
  logic [SER_BYTE_W-1:0] tx, last_tx, rx_shift, sel_byte;
  logic [RW-1:0]         ref_cnt;
  logic [PW-1:0]         owner;
  logic                  is_refresh;

  logic [NREQ-1:0]       arb_gnt;
  logic [PW-1:0]         arb_idx;
  logic                  start_grant, start_refresh, half_end;

  assign start_grant   = (state == IDLE) && (|req);
  assign start_refresh = (state == IDLE) && !(|req) && (ref_cnt == RW'(REFRESH_PERIOD - 1));
  assign half_end      = (hcnt == HW'(HALF_DIV - 1));

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .accept  (start_grant),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  always_comb begin
    sel_byte = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) sel_byte = req_data[i*SER_BYTE_W +: SER_BYTE_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Outputs are forced idle while rst is high so an aborted transfer never pulses done.
  always_comb begin
    state_nxt = state;
    gnt       = '0;
    done      = '0;
    busy      = 1'b0;
    sclk      = 1'b0;
    sdata     = 1'b0;
    slatch    = 1'b0;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          if (start_grant) begin
            gnt       = arb_gnt;
            busy      = 1'b1;
            state_nxt = SHIFT;
          end else if (start_refresh) begin
            busy      = 1'b1;
            state_nxt = SHIFT;
          end
        end
        SHIFT: begin
          busy  = 1'b1;
          sclk  = phase;
          sdata = tx[0];
          if (phase && half_end && (bit_cnt == 3'd7)) state_nxt = LATCH;
        end
        LATCH: begin
          busy   = 1'b1;
          slatch = 1'b1;
          sdata  = tx[0];
          if (half_end) state_nxt = DONE;
        end
        DONE: begin
          busy = 1'b1;
          if (!is_refresh) done[owner] = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt       <= '0;
      phase      <= 1'b0;
      bit_cnt    <= '0;
      tx         <= '0;
      last_tx    <= '0;
      rx_shift   <= '0;
      rx_data    <= '0;
      ref_cnt    <= '0;
      owner      <= '0;
      is_refresh <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          hcnt    <= '0;
          phase   <= 1'b0;
          bit_cnt <= '0;
          if (start_grant) begin
            tx         <= sel_byte;
            last_tx    <= sel_byte;
            owner      <= arb_idx;
            is_refresh <= 1'b0;
            ref_cnt    <= '0;
          end else if (start_refresh) begin
            tx         <= last_tx;
            is_refresh <= 1'b1;
            ref_cnt    <= '0;
          end else begin
            ref_cnt <= ref_cnt + RW'(1);
          end
        end
        SHIFT: begin
          if (phase && (hcnt == '0)) rx_shift[bit_cnt] <= sdatain;
          if (half_end) begin
            hcnt  <= '0;
            phase <= ~phase;
            // The last bit is not shifted out so sdata keeps bit 7 through LATCH.
            if (phase && (bit_cnt != 3'd7)) begin
              bit_cnt <= bit_cnt + 3'd1;
              tx      <= tx >> 1;
            end
          end else begin
            hcnt <= hcnt + HW'(1);
          end
        end
        LATCH: begin
          if (half_end) hcnt <= '0;
          else          hcnt <= hcnt + HW'(1);
        end
        DONE: begin
          rx_data <= rx_shift;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_link_arb.sv
// Directed bench for serial_link_arb with NREQ=2, HALF_DIV=4, REFRESH_PERIOD=200.
module tb_serial_link_arb;

  localparam int unsigned NREQ           = 2;
  localparam int unsigned HALF_DIV       = 4;
  localparam int unsigned REFRESH_PERIOD = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = '0;
  logic [15:0] req_data = '0;
  logic [1:0]  gnt, done;
  logic [7:0]  rx_data;
  logic        busy, sclk, sdata, sdatain, slatch;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] pat = 8'h00;
  logic [3:0] bitpos;
  logic       prev_sclk;

  always #5 clk = ~clk;

  serial_link_arb #(
    .NREQ          (NREQ),
    .HALF_DIV      (HALF_DIV),
    .REFRESH_PERIOD(REFRESH_PERIOD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .done     (done),
    .rx_data  (rx_data),
    .busy     (busy),
    .sclk     (sclk),
    .sdata    (sdata),
    .sdatain  (sdatain),
    .slatch   (slatch)
  );

  // Input shift register model: presents pat LSB first, advancing on each sclk fall.
  initial begin
    sdatain   = 1'b0;
    bitpos    = '0;
    prev_sclk = 1'b0;
    forever begin
      @(negedge clk);
      if (!busy || slatch) bitpos = '0;
      else if (prev_sclk && !sclk) bitpos = bitpos + 4'd1;
      prev_sclk = sclk;
      sdatain   = pat[bitpos[2:0]];
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [6:0] obs;
    repeat (3) @(posedge clk);
    @(negedge clk);
    obs = {gnt, done, busy, sclk, slatch};
    vectors++;
    if (obs !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b expected %b", obs, 7'b0);
    end
    vectors++;
    if ({sdata, rx_data} !== 9'h000) begin
      miscompares++;
      $display("FAIL reset_data: got sdata=%b rx=%h expected sdata=0 rx=00", sdata, rx_data);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle_busy: got %b expected 0", busy);
    end
    next_cycle();
  endtask

  task automatic test_single();
    logic [7:0] b;
    logic [6:0] obs, exp_v;
    logic       e_sclk, e_slatch, e_busy;
    logic [1:0] e_gnt, e_done;
    b   = 8'hA5;
    pat = 8'h3C;
    for (int c = 0; c <= 70; c++) begin
      if (c == 0) begin
        req_data[7:0] = b;
        req           = 2'b01;
      end
      if (c == 1) req = 2'b00;
      @(negedge clk);
      e_gnt    = (c == 0) ? 2'b01 : 2'b00;
      e_done   = (c == 69) ? 2'b01 : 2'b00;
      e_busy   = (c <= 69);
      e_sclk   = (c >= 1) && (c <= 64) && (((c - 1) % 8) >= 4);
      e_slatch = (c >= 65) && (c <= 68);
      exp_v    = {e_gnt, e_done, e_busy, e_sclk, e_slatch};
      obs      = {gnt, done, busy, sclk, slatch};
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL single_ctrl c=%0d: got %b expected %b", c, obs, exp_v);
      end
      if (c >= 1 && c <= 68) begin
        vectors++;
        if (sdata !== b[(c <= 64) ? (c - 1) / 8 : 7]) begin
          miscompares++;
          $display("FAIL single_sdata c=%0d: got %b expected %b", c, sdata,
                   b[(c <= 64) ? (c - 1) / 8 : 7]);
        end
      end
      if (c == 70) begin
        vectors++;
        if (rx_data !== 8'h3C) begin
          miscompares++;
          $display("FAIL single_rx: got %h expected 3c", rx_data);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_refresh();
    logic [7:0] b;
    logic [6:0] obs, exp_v;
    b   = 8'hA5;
    pat = 8'h96;
    for (int i = 0; i < 198; i++) begin
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0) begin
        miscompares++;
        $display("FAIL refresh_early i=%0d: got busy=%b expected 0", i, busy);
      end
      next_cycle();
    end
    for (int c = 0; c <= 70; c++) begin
      @(negedge clk);
      exp_v = {2'b00, 2'b00, (c <= 69), (c >= 1) && (c <= 64) && (((c - 1) % 8) >= 4),
               (c >= 65) && (c <= 68)};
      obs   = {gnt, done, busy, sclk, slatch};
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL refresh_ctrl c=%0d: got %b expected %b", c, obs, exp_v);
      end
      if (c >= 1 && c <= 64) begin
        vectors++;
        if (sdata !== b[(c - 1) / 8]) begin
          miscompares++;
          $display("FAIL refresh_sdata c=%0d: got %b expected %b", c, sdata, b[(c - 1) / 8]);
        end
      end
      if (c == 70) begin
        vectors++;
        if (rx_data !== 8'h96) begin
          miscompares++;
          $display("FAIL refresh_rx: got %h expected 96", rx_data);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] b;
    logic [4:0] obs, exp_v;
    b   = 8'h5A;
    pat = 8'hE1;
    req_data[15:8] = b;
    repeat (198) next_cycle();
    for (int c = 0; c <= 70; c++) begin
      if (c == 0) req = 2'b10;
      if (c == 1) req = 2'b00;
      @(negedge clk);
      exp_v = {(c == 0) ? 2'b10 : 2'b00, (c == 69) ? 2'b10 : 2'b00, (c <= 69)};
      obs   = {gnt, done, busy};
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL simul_ctrl c=%0d: got %b expected %b", c, obs, exp_v);
      end
      if (c >= 1 && c <= 64) begin
        vectors++;
        if (sdata !== b[(c - 1) / 8]) begin
          miscompares++;
          $display("FAIL simul_sdata c=%0d: got %b expected %b", c, sdata, b[(c - 1) / 8]);
        end
      end
      if (c == 70) begin
        vectors++;
        if (rx_data !== 8'hE1) begin
          miscompares++;
          $display("FAIL simul_rx: got %h expected e1", rx_data);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_round_robin();
    logic [4:0] obs, exp_v;
    logic [1:0] e_gnt, e_done;
    pat = 8'h4B;
    for (int c = 0; c <= 210; c++) begin
      if (c == 0) begin
        req_data = 16'h2211;
        req      = 2'b11;
      end
      if (c == 141) req = 2'b00;
      @(negedge clk);
      e_gnt  = (c == 0 || c == 140) ? 2'b01 : (c == 70) ? 2'b10 : 2'b00;
      e_done = (c == 69 || c == 209) ? 2'b01 : (c == 139) ? 2'b10 : 2'b00;
      exp_v  = {e_gnt, e_done, (c <= 209)};
      obs    = {gnt, done, busy};
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL rr_ctrl c=%0d: got %b expected %b", c, obs, exp_v);
      end
      if (c == 70 || c == 210) begin
        vectors++;
        if (rx_data !== 8'h4B) begin
          miscompares++;
          $display("FAIL rr_rx c=%0d: got %h expected 4b", c, rx_data);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    logic [6:0] obs;
    logic [4:0] o5, exp_v;
    pat = 8'h55;
    for (int c = 0; c <= 110; c++) begin
      if (c == 0) begin
        req_data[7:0] = 8'hFF;
        req           = 2'b01;
      end
      if (c == 1)  req = 2'b00;
      if (c == 30) rst = 1'b1;
      if (c == 31) rst = 1'b0;
      @(negedge clk);
      if (c == 0) begin
        vectors++;
        if ({gnt, busy} !== 3'b011) begin
          miscompares++;
          $display("FAIL abort_grant: got %b expected 011", {gnt, busy});
        end
      end
      if (c == 31) begin
        obs = {gnt, done, busy, sclk, slatch};
        vectors++;
        if ({obs, sdata, rx_data} !== 16'h0000) begin
          miscompares++;
          $display("FAIL abort_state: got ctrl=%b sdata=%b rx=%h expected all zero", obs, sdata,
                   rx_data);
        end
      end
      if (c > 31) begin
        vectors++;
        if ({done, busy} !== 3'b000) begin
          miscompares++;
          $display("FAIL abort_nodone c=%0d: got %b expected 000", c, {done, busy});
        end
      end
      next_cycle();
    end
    b   = 8'hC3;
    pat = 8'h81;
    req_data[15:8] = b;
    for (int c = 0; c <= 70; c++) begin
      if (c == 0) req = 2'b10;
      if (c == 1) req = 2'b00;
      @(negedge clk);
      exp_v = {(c == 0) ? 2'b10 : 2'b00, (c == 69) ? 2'b10 : 2'b00, (c <= 69)};
      o5    = {gnt, done, busy};
      vectors++;
      if (o5 !== exp_v) begin
        miscompares++;
        $display("FAIL after_abort_ctrl c=%0d: got %b expected %b", c, o5, exp_v);
      end
      if (c >= 1 && c <= 64) begin
        vectors++;
        if (sdata !== b[(c - 1) / 8]) begin
          miscompares++;
          $display("FAIL after_abort_sdata c=%0d: got %b expected %b", c, sdata, b[(c - 1) / 8]);
        end
      end
      if (c == 70) begin
        vectors++;
        if (rx_data !== 8'h81) begin
          miscompares++;
          $display("FAIL after_abort_rx: got %h expected 81", rx_data);
        end
      end
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_refresh();
    test_simultaneous();
    test_round_robin();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
